// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and transmitter signal bundle for uart_tx_arbiter
interface uart_tx_arbiter_if #(
   parameter int P_NUM = 4
);
   logic [P_NUM-1:0]   REQ;
   logic [8*P_NUM-1:0] DATA_IN;
   logic [P_NUM-1:0]   ACK;
   logic [2:0]         GRANT;
   logic               ARB_BUSY;
   logic               ERR;
   logic               TX_START;
   logic [7:0]         TX_DATA;
   logic               TX_BUSY;

   modport master (
      input  REQ, DATA_IN, TX_BUSY,
      output ACK, GRANT, ARB_BUSY, ERR, TX_START, TX_DATA
   );

   modport slave (
      output REQ, DATA_IN, TX_BUSY,
      input  ACK, GRANT, ARB_BUSY, ERR, TX_START, TX_DATA
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter among P_NUM byte requesters
module uart_tx_arbiter #(
   parameter int P_NUM     = 4,
   parameter int P_TIMEOUT = 1024,
   parameter int P_GAP     = 2
) (
   input logic               CLK,
   input logic               RESET,
   uart_tx_arbiter_if.master bus
);
   localparam int CNT_MAX = (P_TIMEOUT > P_GAP) ? P_TIMEOUT : P_GAP;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [2:0]    LAST_RST = 3'(P_NUM - 1);
   localparam logic [CW-1:0] TO_LAST  = CW'(P_TIMEOUT - 1);
   localparam logic [CW-1:0] GAP_LAST = CW'((P_GAP > 0) ? P_GAP - 1 : 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WAIT_BUSY,
      S_WAIT_DONE,
      S_GAP
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [2:0]       last_q, last_d;
   logic [2:0]       grant_q, grant_d;
   logic [P_NUM-1:0] ack_q, ack_d;
   logic             tx_start_q, tx_start_d;
   logic             err_q, err_d;
   logic             arb_busy_q, arb_busy_d;
   logic [7:0]       tx_data_q, tx_data_d;

   logic             found;
   logic [2:0]       sel;
   logic [P_NUM-1:0] sel_oh;
   logic [7:0]       sel_data;

   // Two passes: first requester above the pointer, otherwise wrap to the lowest one.
   always_comb begin : pick
      found    = 1'b0;
      sel      = '0;
      sel_oh   = '0;
      sel_data = '0;
      for (int i = 0; i < P_NUM; i++) begin
         if (!found && bus.REQ[i] && (i > int'(last_q))) begin
            found     = 1'b1;
            sel       = 3'(i);
            sel_oh[i] = 1'b1;
            sel_data  = bus.DATA_IN[8*i +: 8];
         end
      end
      for (int i = 0; i < P_NUM; i++) begin
         if (!found && bus.REQ[i]) begin
            found     = 1'b1;
            sel       = 3'(i);
            sel_oh[i] = 1'b1;
            sel_data  = bus.DATA_IN[8*i +: 8];
         end
      end
   end

   always_comb begin : fsm
      state_d    = state_q;
      cnt_d      = cnt_q;
      last_d     = last_q;
      grant_d    = grant_q;
      tx_data_d  = tx_data_q;
      ack_d      = '0;
      tx_start_d = 1'b0;
      err_d      = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (!bus.TX_BUSY && found) begin
               tx_data_d  = sel_data;
               grant_d    = sel;
               last_d     = sel;
               ack_d      = sel_oh;
               tx_start_d = 1'b1;
               state_d    = S_START;
            end
         end
         S_START: begin
            cnt_d   = '0;
            state_d = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (bus.TX_BUSY) begin
               state_d = S_WAIT_DONE;
            end else if (cnt_q == TO_LAST) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_WAIT_DONE: begin
            if (!bus.TX_BUSY) begin
               cnt_d   = '0;
               state_d = (P_GAP == 0) ? S_IDLE : S_GAP;
            end
         end
         S_GAP: begin
            if (cnt_q == GAP_LAST) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
      arb_busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         last_q     <= LAST_RST;
         grant_q    <= '0;
         ack_q      <= '0;
         tx_start_q <= 1'b0;
         err_q      <= 1'b0;
         arb_busy_q <= 1'b0;
         tx_data_q  <= 8'h00;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         last_q     <= last_d;
         grant_q    <= grant_d;
         ack_q      <= ack_d;
         tx_start_q <= tx_start_d;
         err_q      <= err_d;
         arb_busy_q <= arb_busy_d;
         tx_data_q  <= tx_data_d;
      end
   end

   assign bus.ACK      = ack_q;
   assign bus.GRANT    = grant_q;
   assign bus.ARB_BUSY = arb_busy_q;
   assign bus.ERR      = err_q;
   assign bus.TX_START = tx_start_q;
   assign bus.TX_DATA  = tx_data_q;
endmodule
